// File: rtl/dual_tone_dds_pkg.sv
// Shared constants, FSM encoding and the elaboration-time sine generator
// used by the dual-tone DDS test-signal source.
package dual_tone_dds_pkg;

  localparam int ACC_W  = 32;
  localparam int LUT_AW = 8;
  localparam int LUT_DW = 22;
  localparam int DATA_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_WT_A = 3'd2,
    ST_RD_B = 3'd3,
    ST_WT_B = 3'd4,
    ST_SUM  = 3'd5
  } dds_state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // round((2^LUT_DW-1) * sin((idx+0.5)*pi/512)), evaluated with a Taylor
  // series in 60-bit fixed point so no real arithmetic reaches synthesis.
  function automatic logic [LUT_DW-1:0] sine_rom_value(input int unsigned idx);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] scaled;
    x    = (128'h3243F6A8885A308D * 128'(2 * idx + 1)) >> 10;
    x2   = (x * x) >> 60;
    term = x;
    acc  = x;
    for (int k = 1; k <= 12; k++) begin
      term = ((term * x2) >> 60) / 128'(4 * k * k + 2 * k);
      if (k % 2 == 1) acc = acc - term;
      else            acc = acc + term;
    end
    scaled = acc * ((128'd1 << LUT_DW) - 128'd1) + (128'd1 << 59);
    return LUT_DW'(scaled >> 60);
  endfunction

endpackage

// File: rtl/dual_tone_dds_sine_quarter_rom.sv
// Quarter-wave sine table, 256 x 22 unsigned, one-cycle synchronous read.
// Contents are fixed at elaboration from the package generator.
module sine_quarter_rom
  import dual_tone_dds_pkg::*;
(
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [LUT_DW-1:0] data_o
);

  logic [LUT_DW-1:0] rom_tbl [2**LUT_AW];
  logic [LUT_DW-1:0] data_q;

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
    localparam logic [LUT_DW-1:0] ENTRY = sine_rom_value(g);
    assign rom_tbl[g] = ENTRY;
  end

  always_ff @(posedge clk) begin
    data_q <= rom_tbl[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/dual_tone_dds.sv
// Wanted tone plus optional attenuated hum tone, one summed sample per strobe,
// with a single quarter-wave ROM shared by the two phase accumulators.
module dual_tone_dds
  import dual_tone_dds_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [ACC_W-1:0]  fcw_sig,
  input  logic [ACC_W-1:0]  fcw_hum,
  input  logic              hum_en,
  input  logic [1:0]        hum_att,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  dds_state_e               state_q;
  logic [ACC_W-1:0]         acc_a_q, acc_b_q;
  logic [ACC_W-1:0]         fcw_sig_q, fcw_hum_q;
  logic                     hum_en_q;
  logic [1:0]               hum_att_q;
  logic signed [LUT_DW:0]   term_a_q, term_b_q;
  logic [DATA_W-1:0]        data_out_q;
  logic                     data_valid_q;
  logic                     overrun_q;

  logic                     rd_b_d;
  logic [LUT_AW-1:0]        idx_d;
  logic                     mirror_d;
  logic [LUT_AW-1:0]        rom_addr_d;
  logic [LUT_DW-1:0]        rom_data;
  logic [1:0]               quad_d;
  logic signed [LUT_DW:0]   mag_d;
  logic signed [LUT_DW:0]   rom_term_d;
  logic signed [LUT_DW:0]   hum_term_d;
  logic [DATA_W:0]          sum_d;
  logic [DATA_W-1:0]        sat_d;

  // Accumulators stay still until SUM, so the read and capture stages can
  // both look at the live phase of the tone they are serving.
  always_comb begin
    rd_b_d     = (state_q == ST_RD_B);
    idx_d      = rd_b_d ? acc_b_q[ACC_W-3 -: LUT_AW] : acc_a_q[ACC_W-3 -: LUT_AW];
    mirror_d   = rd_b_d ? acc_b_q[ACC_W-2] : acc_a_q[ACC_W-2];
    rom_addr_d = mirror_d ? ~idx_d : idx_d;

    quad_d     = (state_q == ST_WT_B) ? acc_b_q[ACC_W-1 -: 2] : acc_a_q[ACC_W-1 -: 2];
    mag_d      = $signed({1'b0, rom_data});
    rom_term_d = (quad_d == QUAD_2 || quad_d == QUAD_3) ? -mag_d : mag_d;
    hum_term_d = rom_term_d >>> hum_att_q;

    sum_d = {{(DATA_W-LUT_DW){term_a_q[LUT_DW]}}, term_a_q}
          + {{(DATA_W-LUT_DW){term_b_q[LUT_DW]}}, term_b_q};
    if (sum_d[DATA_W] != sum_d[DATA_W-1])
      sat_d = sum_d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_d = sum_d[DATA_W-1:0];
  end

  sine_quarter_rom u_rom (
    .clk    (clk),
    .addr_i (rom_addr_d),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      fcw_sig_q    <= '0;
      fcw_hum_q    <= '0;
      hum_en_q     <= 1'b0;
      hum_att_q    <= '0;
      term_a_q     <= '0;
      term_b_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (sample_en && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (sample_en) begin
            fcw_sig_q <= fcw_sig;
            fcw_hum_q <= fcw_hum;
            hum_en_q  <= hum_en;
            hum_att_q <= hum_att;
            state_q   <= ST_RD_A;
          end
        end
        ST_RD_A: state_q <= ST_WT_A;
        ST_WT_A: begin
          term_a_q <= rom_term_d;
          state_q  <= ST_RD_B;
        end
        ST_RD_B: state_q <= ST_WT_B;
        ST_WT_B: begin
          term_b_q <= hum_en_q ? hum_term_d : '0;
          state_q  <= ST_SUM;
        end
        ST_SUM: begin
          data_out_q   <= sat_d;
          data_valid_q <= 1'b1;
          acc_a_q      <= acc_a_q + fcw_sig_q;
          acc_b_q      <= hum_en_q ? (acc_b_q + fcw_hum_q) : '0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule
